// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared constants and types for the pipeline hazard controller.
//   FWD_*          : encodings of the E-stage ALU operand forwarding select
//   *_DEF          : default mul/div latencies and counter width
//   md_state_t     : state of the multi-cycle mul/div sequencer
//   reg_match()    : qualified register-dependency compare
// ---------------------------------------------------------------------------
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;   // operand from register file
   localparam logic [1:0] FWD_W  = 2'b01;   // operand from writeback stage
   localparam logic [1:0] FWD_M  = 2'b10;   // operand from memory stage

   localparam int MULT_LAT_DEF = 4;
   localparam int DIV_LAT_DEF  = 32;
   localparam int CNT_W_DEF    = 6;

   typedef enum logic [0:0] {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // A dependency only exists when the producer actually writes and the
   // register is not $zero (writes to $zero are discarded by the RF).
   function automatic logic reg_match(input logic [4:0] src,
                                      input logic [4:0] dst,
                                      input logic       we);
      return we && (src != 5'd0) && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of pipeline-status inputs and stall/flush/forward outputs exchanged
// between the datapath and the hazard controller.
//   master : datapath side (drives stage status, consumes control)
//   slave  : hazard controller side
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

   // Stage status from the datapath
   logic [4:0] RsD, RtD;
   logic [4:0] RsE, RtE;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic       MemtoRegE, MemtoRegM;
   logic       BranchD, JumpD, PCSrcD;
   logic       MdStartE, MdOpE, MdStartD, MfhiloD;

   // Control back to the datapath
   logic       StallF, StallD;
   logic       FlushD, FlushE;
   logic       ForwardAD, ForwardBD;
   logic [1:0] ForwardAE, ForwardBE;
   logic       MdBusy, MdDone;

   modport master (
      output RsD, RtD, RsE, RtE,
      output WriteRegE, WriteRegM, WriteRegW,
      output RegWriteE, RegWriteM, RegWriteW,
      output MemtoRegE, MemtoRegM,
      output BranchD, JumpD, PCSrcD,
      output MdStartE, MdOpE, MdStartD, MfhiloD,
      input  StallF, StallD, FlushD, FlushE,
      input  ForwardAD, ForwardBD, ForwardAE, ForwardBE,
      input  MdBusy, MdDone
   );

   modport slave (
      input  RsD, RtD, RsE, RtE,
      input  WriteRegE, WriteRegM, WriteRegW,
      input  RegWriteE, RegWriteM, RegWriteW,
      input  MemtoRegE, MemtoRegM,
      input  BranchD, JumpD, PCSrcD,
      input  MdStartE, MdOpE, MdStartD, MfhiloD,
      output StallF, StallD, FlushD, FlushE,
      output ForwardAD, ForwardBD, ForwardAE, ForwardBE,
      output MdBusy, MdDone
   );

endinterface

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
// Occupancy tracker for the multi-cycle multiply/divide unit.
//   clk, rst : clock, asynchronous active-high reset
//   start    : mul/div instruction in E this cycle
//   op       : 0 = multiply, 1 = divide
//   busy     : unit occupied (BUSY state)
//   done     : HI/LO written at the end of this cycle (last BUSY cycle)
// A start in cycle t gives busy in t+1..t+LAT and done in t+LAT.
// ---------------------------------------------------------------------------
module md_sequencer
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic op,
   output logic busy,
   output logic done
);

   // Counter is loaded with LAT-1 so that the done cycle is the one where
   // it reaches zero.
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

   md_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
      end else if (state_reg == MD_IDLE) begin
         if (start) begin
            state_reg <= MD_BUSY;
            cnt_reg   <= op ? DIV_CNT : MULT_CNT;
         end
      end else begin
         // A new start while busy is a protocol violation and is ignored.
         if (cnt_reg == '0) begin
            state_reg <= MD_IDLE;
         end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
      end
   end

   assign busy = (state_reg == MD_BUSY);
   assign done = (state_reg == MD_BUSY) && (cnt_reg == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central hazard/sequencing controller for the 5-stage pipeline.
//   clk, rst : clock, asynchronous active-high reset (forces all outputs 0)
//   hz       : slave side of hazard_ctrl_if
//              inputs : D/E source regs, E/M/W destinations and write
//                       enables, load flags, branch/jump, mul/div status
//              outputs: StallF/StallD/FlushD/FlushE, D- and E-stage
//                       forwarding selects, MdBusy/MdDone
// Everything except the mul/div sequencer state is combinational.
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   hazard_ctrl_if.slave hz
);

   logic       md_busy, md_done;
   logic       lwstall, brstall, mdstall, stall;
   logic       fwd_ad, fwd_bd;
   logic [1:0] fwd_ae, fwd_be;

   md_sequencer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) u_md_seq (
      .clk   (clk),
      .rst   (rst),
      .start (hz.MdStartE),
      .op    (hz.MdOpE),
      .busy  (md_busy),
      .done  (md_done)
   );

   // E-stage ALU operand forwarding: the younger producer (M) wins over W.
   always_comb begin
      fwd_ae = FWD_RF;
      if (reg_match(hz.RsE, hz.WriteRegM, hz.RegWriteM))
         fwd_ae = FWD_M;
      else if (reg_match(hz.RsE, hz.WriteRegW, hz.RegWriteW))
         fwd_ae = FWD_W;

      fwd_be = FWD_RF;
      if (reg_match(hz.RtE, hz.WriteRegM, hz.RegWriteM))
         fwd_be = FWD_M;
      else if (reg_match(hz.RtE, hz.WriteRegW, hz.RegWriteW))
         fwd_be = FWD_W;
   end

   // D-stage branch comparator can only take an ALU result sitting in M.
   assign fwd_ad = reg_match(hz.RsD, hz.WriteRegM, hz.RegWriteM);
   assign fwd_bd = reg_match(hz.RtD, hz.WriteRegM, hz.RegWriteM);

   // Load-use: loaded data is not available until W.
   assign lwstall = hz.MemtoRegE &&
                    (reg_match(hz.RsD, hz.WriteRegE, hz.RegWriteE) ||
                     reg_match(hz.RtD, hz.WriteRegE, hz.RegWriteE));

   // Branch compares in D: wait for an ALU result still in E, or for a
   // load still in M.
   assign brstall = hz.BranchD &&
                    ((reg_match(hz.RsD, hz.WriteRegE, hz.RegWriteE) ||
                      reg_match(hz.RtD, hz.WriteRegE, hz.RegWriteE)) ||
                     (hz.MemtoRegM &&
                      (reg_match(hz.RsD, hz.WriteRegM, hz.RegWriteM) ||
                       reg_match(hz.RtD, hz.WriteRegM, hz.RegWriteM))));

   // HI/LO users and new mul/div ops wait while the unit is (about to be)
   // occupied; MdStartE covers the cycle before BUSY is visible.
   assign mdstall = (hz.MfhiloD || hz.MdStartD) && (hz.MdStartE || md_busy);

   assign stall = lwstall || brstall || mdstall;

   // Outputs are held at zero for the whole reset pulse.
   assign hz.StallF    = !rst && stall;
   assign hz.StallD    = !rst && stall;
   assign hz.FlushE    = !rst && stall;
   assign hz.FlushD    = !rst && (hz.PCSrcD || hz.JumpD) && !stall;
   assign hz.ForwardAD = !rst && fwd_ad;
   assign hz.ForwardBD = !rst && fwd_bd;
   assign hz.ForwardAE = rst ? 2'b00 : fwd_ae;
   assign hz.ForwardBE = rst ? 2'b00 : fwd_be;
   assign hz.MdBusy    = !rst && md_busy;
   assign hz.MdDone    = !rst && md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl: one task per feature, expected values
// worked out by hand from the controller behaviour.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   hazard_ctrl_if hif ();

   hazard_ctrl #(
      .MULT_LAT (4),
      .DIV_LAT  (32),
      .CNT_W    (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A mul/div start while the unit is busy should never be issued.
   always @(negedge clk) begin
      if (!rst && hif.MdStartE && hif.MdBusy) begin
         errors++;
         $display("FAIL protocol: MdStartE=1 while MdBusy=1 at %0t", $time);
      end
   end

   task automatic clear_inputs();
      hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
      hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
      hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
      hif.MemtoRegE = 0; hif.MemtoRegM = 0;
      hif.BranchD = 0; hif.JumpD = 0; hif.PCSrcD = 0;
      hif.MdStartE = 0; hif.MdOpE = 0; hif.MdStartD = 0; hif.MfhiloD = 0;
   endtask

   // Move to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      // Hazards present on the inputs must still be masked during reset.
      hif.RsE = 9; hif.WriteRegM = 9; hif.RegWriteM = 1;
      hif.RsD = 8; hif.WriteRegE = 8; hif.RegWriteE = 1; hif.MemtoRegE = 1;
      hif.JumpD = 1;
      next_cycle();
      next_cycle();
      #1;
      checks++;
      if (hif.StallD !== 1'b0) begin
         errors++; $display("FAIL reset_stalld: got %b expected 0", hif.StallD);
      end
      checks++;
      if (hif.ForwardAE !== 2'b00) begin
         errors++; $display("FAIL reset_fwdae: got %b expected 00", hif.ForwardAE);
      end
      checks++;
      if (hif.FlushD !== 1'b0) begin
         errors++; $display("FAIL reset_flushd: got %b expected 0", hif.FlushD);
      end
      checks++;
      if ({hif.MdBusy, hif.MdDone} !== 2'b00) begin
         errors++; $display("FAIL reset_md: busy/done got %b expected 00", {hif.MdBusy, hif.MdDone});
      end
      clear_inputs();
      rst = 1'b0;
      next_cycle();
      $display("test_reset done");
   endtask

   task automatic test_load_use();
      clear_inputs();
      hif.WriteRegE = 8; hif.MemtoRegE = 1; hif.RegWriteE = 1; hif.RsD = 8;
      #1;
      checks++;
      if ({hif.StallF, hif.StallD, hif.FlushE, hif.FlushD} !== 4'b1110) begin
         errors++; $display("FAIL lw_rs: StallF/StallD/FlushE/FlushD got %b expected 1110",
                            {hif.StallF, hif.StallD, hif.FlushE, hif.FlushD});
      end
      hif.RsD = 0; hif.RtD = 8;
      #1;
      checks++;
      if (hif.StallD !== 1'b1) begin
         errors++; $display("FAIL lw_rt: StallD got %b expected 1", hif.StallD);
      end
      hif.RtD = 0; hif.WriteRegE = 0;
      #1;
      checks++;
      if ({hif.StallF, hif.StallD, hif.FlushE, hif.FlushD} !== 4'b0000) begin
         errors++; $display("FAIL lw_zero: got %b expected 0000",
                            {hif.StallF, hif.StallD, hif.FlushE, hif.FlushD});
      end
      // A non-load producer in E is forwarded, not stalled.
      hif.WriteRegE = 8; hif.RsD = 8; hif.MemtoRegE = 0;
      #1;
      checks++;
      if (hif.StallD !== 1'b0) begin
         errors++; $display("FAIL lw_noload: StallD got %b expected 0", hif.StallD);
      end
      clear_inputs();
      next_cycle();
      $display("test_load_use done");
   endtask

   task automatic test_forwarding();
      clear_inputs();
      hif.RsE = 9; hif.WriteRegM = 9; hif.RegWriteM = 1;
      hif.WriteRegW = 9; hif.RegWriteW = 1;
      #1;
      checks++;
      if (hif.ForwardAE !== 2'b10) begin
         errors++; $display("FAIL fwd_m_prio: ForwardAE got %b expected 10", hif.ForwardAE);
      end
      hif.RegWriteM = 0;
      #1;
      checks++;
      if (hif.ForwardAE !== 2'b01) begin
         errors++; $display("FAIL fwd_w: ForwardAE got %b expected 01", hif.ForwardAE);
      end
      hif.RsE = 0;
      #1;
      checks++;
      if (hif.ForwardAE !== 2'b00) begin
         errors++; $display("FAIL fwd_zero: ForwardAE got %b expected 00", hif.ForwardAE);
      end
      // B operand from M, A operand from W simultaneously.
      hif.RsE = 3; hif.WriteRegW = 3; hif.RegWriteW = 1;
      hif.RtE = 7; hif.WriteRegM = 7; hif.RegWriteM = 1;
      #1;
      checks++;
      if ({hif.ForwardAE, hif.ForwardBE} !== 4'b0110) begin
         errors++; $display("FAIL fwd_ab: AE/BE got %b expected 0110", {hif.ForwardAE, hif.ForwardBE});
      end
      // D-stage comparator forward from M only.
      hif.RsD = 3; hif.RtD = 7;
      #1;
      checks++;
      if ({hif.ForwardAD, hif.ForwardBD} !== 2'b01) begin
         errors++; $display("FAIL fwd_d: AD/BD got %b expected 01", {hif.ForwardAD, hif.ForwardBD});
      end
      clear_inputs();
      next_cycle();
      $display("test_forwarding done");
   endtask

   task automatic test_branch();
      clear_inputs();
      hif.BranchD = 1; hif.PCSrcD = 1; hif.RtD = 5;
      hif.WriteRegE = 5; hif.RegWriteE = 1;
      #1;
      checks++;
      if ({hif.StallD, hif.FlushD} !== 2'b10) begin
         errors++; $display("FAIL br_stall: StallD/FlushD got %b expected 10", {hif.StallD, hif.FlushD});
      end
      next_cycle();
      hif.WriteRegE = 0; hif.RegWriteE = 0;
      #1;
      checks++;
      if ({hif.StallD, hif.FlushD} !== 2'b01) begin
         errors++; $display("FAIL br_taken: StallD/FlushD got %b expected 01", {hif.StallD, hif.FlushD});
      end
      // Load result still in M also holds the branch.
      hif.RsD = 6; hif.WriteRegM = 6; hif.RegWriteM = 1; hif.MemtoRegM = 1;
      #1;
      checks++;
      if ({hif.StallD, hif.FlushD} !== 2'b10) begin
         errors++; $display("FAIL br_loadm: StallD/FlushD got %b expected 10", {hif.StallD, hif.FlushD});
      end
      clear_inputs();
      hif.JumpD = 1;
      #1;
      checks++;
      if ({hif.StallD, hif.FlushD} !== 2'b01) begin
         errors++; $display("FAIL jump: StallD/FlushD got %b expected 01", {hif.StallD, hif.FlushD});
      end
      clear_inputs();
      next_cycle();
      $display("test_branch done");
   endtask

   task automatic test_mult_mfhi();
      logic exp_stall, exp_busy, exp_done;
      clear_inputs();
      hif.MfhiloD = 1; hif.MdStartE = 1; hif.MdOpE = 0;
      // k = cycles after the start cycle t
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) begin
            next_cycle();
            hif.MdStartE = 0;
         end
         #1;
         exp_stall = (k <= 4);
         exp_busy  = (k >= 1) && (k <= 4);
         exp_done  = (k == 4);
         checks++;
         if ({hif.StallD, hif.MdBusy, hif.MdDone} !== {exp_stall, exp_busy, exp_done}) begin
            errors++;
            $display("FAIL mult_t%0d: StallD/MdBusy/MdDone got %b expected %b",
                     k, {hif.StallD, hif.MdBusy, hif.MdDone}, {exp_stall, exp_busy, exp_done});
         end
      end
      clear_inputs();
      next_cycle();
      $display("test_mult_mfhi done");
   endtask

   task automatic test_divide();
      int busy_cnt, done_cnt, stall_cnt, done_at;
      clear_inputs();
      hif.RsD = 4; hif.RtD = 2;         // unrelated instruction in D
      hif.MdStartE = 1; hif.MdOpE = 1;
      #1;
      checks++;
      if (hif.StallD !== 1'b0) begin
         errors++; $display("FAIL div_nostall_t0: StallD got %b expected 0", hif.StallD);
      end
      busy_cnt = 0; done_cnt = 0; stall_cnt = 0; done_at = -1;
      for (int k = 1; k <= 40; k++) begin
         next_cycle();
         hif.MdStartE = 0;
         #1;
         if (hif.MdBusy === 1'b1) busy_cnt++;
         if (hif.MdDone === 1'b1) begin
            done_cnt++;
            done_at = k;
         end
         if (hif.StallD === 1'b1) stall_cnt++;
      end
      checks++;
      if (busy_cnt != 32) begin
         errors++; $display("FAIL div_busy: busy cycles got %0d expected 32", busy_cnt);
      end
      checks++;
      if (done_cnt != 1 || done_at != 32) begin
         errors++; $display("FAIL div_done: pulses got %0d at %0d expected 1 at 32", done_cnt, done_at);
      end
      checks++;
      if (stall_cnt != 0) begin
         errors++; $display("FAIL div_nostall: stall cycles got %0d expected 0", stall_cnt);
      end
      clear_inputs();
      next_cycle();
      $display("test_divide done");
   endtask

   task automatic test_reset_mid_divide();
      int bad_cnt;
      clear_inputs();
      hif.MdStartE = 1; hif.MdOpE = 1;
      for (int k = 1; k <= 10; k++) begin
         next_cycle();
         hif.MdStartE = 0;
      end
      hif.MfhiloD = 1;                  // dependent instruction waiting
      hif.RsE = 9; hif.WriteRegM = 9; hif.RegWriteM = 1;
      #1;
      checks++;
      if ({hif.MdBusy, hif.StallD} !== 2'b11) begin
         errors++; $display("FAIL mid_div_pre: MdBusy/StallD got %b expected 11", {hif.MdBusy, hif.StallD});
      end
      #1;
      rst = 1'b1;                       // mid-cycle, no clock edge involved
      #1;
      checks++;
      if ({hif.MdBusy, hif.MdDone, hif.StallD, hif.StallF, hif.FlushE,
           hif.FlushD, hif.ForwardAE} !== 8'b0) begin
         errors++; $display("FAIL mid_div_rst: outputs got %b expected 00000000",
                            {hif.MdBusy, hif.MdDone, hif.StallD, hif.StallF, hif.FlushE,
                             hif.FlushD, hif.ForwardAE});
      end
      next_cycle();
      clear_inputs();
      rst = 1'b0;
      bad_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (hif.MdBusy !== 1'b0 || hif.MdDone !== 1'b0) bad_cnt++;
         next_cycle();
      end
      checks++;
      if (bad_cnt != 0) begin
         errors++; $display("FAIL mid_div_after: busy/done cycles got %0d expected 0", bad_cnt);
      end
      $display("test_reset_mid_divide done");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_forwarding();
      test_branch();
      test_mult_mfhi();
      test_divide();
      test_reset_mid_divide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
